dffram_wb_bridge: RTL
=====================

DFFRAM_WB_BRIDGE -- requirements
Module: dffram_wb_bridge

Interface
REQ-001 SHALL have parameter CLEAR_ON_RESET, default 1; when 1, all 256 RAM words are zeroed after reset.
REQ-002 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wb_cyc_i  input  1  Wishbone classic cycle.
REQ-005 SHALL have port wb_stb_i  input  1  Wishbone strobe.
REQ-006 SHALL have port wb_we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port wb_sel_i  input  4  byte-lane select.
REQ-008 SHALL have port wb_adr_i  input  32  byte address; only bits [9:2] are used.
REQ-009 SHALL have port wb_dat_i  input  32  write data.
REQ-010 SHALL have port wb_dat_o  output  32  read data.
REQ-011 SHALL have port wb_ack_o  output  1  transfer acknowledge.
REQ-012 SHALL have port ram_en  output  1  to RAM EN.
REQ-013 SHALL have port ram_we  output  4  to RAM byte write enables.
REQ-014 SHALL have port ram_a  output  8  to RAM word address.
REQ-015 SHALL have port ram_di  output  32  to RAM write data.
REQ-016 SHALL have port ram_do  input  32  from RAM; valid the cycle after an enabled access.
REQ-017 SHALL have port init_busy  output  1  high while the clear sweep is pending or running.

Function
REQ-018 SHALL implement the state machine START, CLEAR, IDLE, ACK.
REQ-019 START SHALL last exactly one cycle after RST_N release, with all RAM outputs at 0, then go to CLEAR if CLEAR_ON_RESET=1, else to IDLE.
REQ-020 CLEAR SHALL drive ram_en=1, ram_we=4'hF, ram_di=0, ram_a=cnt every cycle, with 8-bit cnt counting 0..255.
REQ-021 CLEAR SHALL go to IDLE on the cycle after cnt=255 is driven (256 write cycles total); cnt SHALL NOT wrap into a second sweep.
REQ-022 init_busy SHALL be 1 in START (when CLEAR_ON_RESET=1) and in CLEAR, and 0 otherwise.
REQ-023 While not in IDLE, bus requests SHALL cause no RAM access and no ack; a request still held on entry to IDLE SHALL be served normally.
REQ-024 IDLE with wb_cyc_i & wb_stb_i in cycle N SHALL drive, combinationally in cycle N, ram_en=1, ram_a=wb_adr_i[9:2], ram_di=wb_dat_i, and ram_we=wb_sel_i if wb_we_i else 4'h0, then go to ACK.
REQ-025 IDLE without a request SHALL hold ram_en=0, ram_we=0, ram_a=0 and ram_di=0.
REQ-026 ACK (cycle N+1) SHALL assert wb_ack_o = wb_cyc_i & wb_stb_i, drive ram_en=0, and go to IDLE unconditionally.
REQ-027 Every access SHALL have 1-cycle latency, giving a 2-cycle minimum spacing between back-to-back accesses.
REQ-028 wb_dat_o SHALL equal ram_do in ACK for a read, and 32'h0 in all other cases.
REQ-029 A write with wb_sel_i=0 SHALL still be acknowledged while modifying no byte.
REQ-030 A master dropping wb_cyc_i in cycle N+1 SHALL get no ack; the RAM write from cycle N stands.
REQ-031 wb_ack_o SHALL never be high in two consecutive cycles.

Reset
REQ-032 RST_N low SHALL immediately force state=START, cnt=0, wb_ack_o=0, wb_dat_o=0, ram_en=0, ram_we=0, ram_a=0, ram_di=0, and init_busy=CLEAR_ON_RESET, independent of CLK.
REQ-033 RST_N asserted mid-CLEAR or mid-ACK SHALL abort the operation; after release the sweep restarts from address 0.

Verification
REQ-034 Clear sweep: release reset with CLEAR_ON_RESET=1 -> one START cycle, then 256 cycles of ram_we=F/ram_di=0/ram_a=0..255, then init_busy falls; a read of address 0x3FC returns 0.
REQ-035 Byte-lane write: write 0xDEADBEEF to 0x010 with sel=F, then 0x000000AA with sel=1; read 0x010 -> wb_dat_o=0xDEADBEAA, each ack exactly one cycle after its request.
REQ-036 Back-to-back: hold stb for 4 consecutive reads of 0x0,0x4,0x8,0xC -> acks on alternate cycles, and ram_en is never high in an ACK cycle.
REQ-037 Request during clear: assert a read at the second cycle after reset release -> no ack until init_busy=0, then ack one cycle after IDLE entry.
REQ-038 Reset mid-sweep: pull RST_N low at cnt=100 -> all outputs drop asynchronously; after release the sweep restarts at ram_a=0.
REQ-039 Abort: a write whose wb_cyc_i drops in the ACK cycle -> wb_ack_o stays 0, and a read-back shows the data written.

Source files
------------

// File: rtl/dffram_wb_bridge_if.sv
// Wishbone classic slave bus for the DFFRAM bridge; the master drives the
// request fields, the bridge returns read data and the acknowledge.
interface dffram_wb_bridge_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/dffram_wb_bridge.sv
// Wishbone classic to 256x32 DFFRAM bridge: one-cycle-latency accesses and an
// optional post-reset sweep that zeroes every word before the bus is served.
module dffram_wb_bridge #(
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   dffram_wb_bridge_if.slave        wb,
   output logic                     ram_en,
   output logic [3:0]               ram_we,
   output logic [7:0]               ram_a,
   output logic [31:0]              ram_di,
   input  logic [31:0]              ram_do,
   output logic                     init_busy
);

   typedef enum logic [1:0] {
      START = 2'd0,
      CLEAR = 2'd1,
      IDLE  = 2'd2,
      ACK   = 2'd3
   } state_t;

   state_t     state;
   logic [7:0] cnt;
   logic       rd_q;
   logic       req;
   logic       unused_adr;

   assign req        = wb.wb_cyc_i & wb.wb_stb_i;
   assign unused_adr = ^{wb.wb_adr_i[31:10], wb.wb_adr_i[1:0]};

   // cnt parks at 255 when the sweep ends so it can never start a second pass
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= START;
         cnt   <= 8'd0;
         rd_q  <= 1'b0;
      end else begin
         case (state)
            START: state <= CLEAR_ON_RESET ? CLEAR : IDLE;
            CLEAR: begin
               if (cnt == 8'hFF) state <= IDLE;
               else              cnt   <= cnt + 8'd1;
            end
            IDLE: begin
               if (req) begin
                  state <= ACK;
                  rd_q  <= ~wb.wb_we_i;
               end
            end
            ACK:     state <= IDLE;
            default: state <= START;
         endcase
      end
   end

   // RAM strobes are combinational so the RAM samples them on the same edge
   // that moves IDLE to ACK; ram_do then lands exactly in the ACK cycle.
   always_comb begin
      ram_en      = 1'b0;
      ram_we      = 4'h0;
      ram_a       = 8'h00;
      ram_di      = 32'h0;
      wb.wb_ack_o = 1'b0;
      wb.wb_dat_o = 32'h0;
      init_busy   = 1'b0;
      case (state)
         START: init_busy = CLEAR_ON_RESET;
         CLEAR: begin
            init_busy = 1'b1;
            ram_en    = 1'b1;
            ram_we    = 4'hF;
            ram_a     = cnt;
         end
         IDLE: begin
            if (req) begin
               ram_en = 1'b1;
               ram_a  = wb.wb_adr_i[9:2];
               ram_di = wb.wb_dat_i;
               ram_we = wb.wb_we_i ? wb.wb_sel_i : 4'h0;
            end
         end
         ACK: begin
            wb.wb_ack_o = req;
            if (rd_q) wb.wb_dat_o = ram_do;
         end
         default: ;
      endcase
   end

endmodule
